// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch, dmem wait and halt,
// resolved in fixed priority, with saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic             branch_taken,
  input  logic             halt_req,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             ifid_write,
  output logic             if_flush,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT, HALTED} state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu_hz, stall_inc, flush_inc;
  logic             pc_write_c, pc_sel_c, ifid_write_c, if_flush_c;
  logic             idex_bubble_c, pipe_freeze_c, halted_c;

  assign lu_hz = idex_memread && (idex_rd != 5'd0) && id_valid &&
                 ((id_use_rs1 && (idex_rd == id_rs1)) || (id_use_rs2 && (idex_rd == id_rs2)));

  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    pc_write_c    = 1'b1;
    pc_sel_c      = 1'b0;
    ifid_write_c  = 1'b1;
    if_flush_c    = 1'b0;
    idex_bubble_c = 1'b0;
    pipe_freeze_c = 1'b0;
    halted_c      = 1'b0;
    case (state_q)
      // MEM_WAIT with mem_busy low is evaluated exactly like RUN
      RUN, MEM_WAIT: begin
        state_d = RUN;
        if (mem_busy) begin
          pipe_freeze_c = 1'b1;
          pc_write_c    = 1'b0;
          ifid_write_c  = 1'b0;
          stall_inc     = 1'b1;
          state_d       = MEM_WAIT;
        end else if (lu_hz) begin
          pc_write_c    = 1'b0;
          ifid_write_c  = 1'b0;
          idex_bubble_c = 1'b1;
          stall_inc     = 1'b1;
        end else if (id_valid && branch_taken) begin
          pc_sel_c      = 1'b1;
          if_flush_c    = 1'b1;
          idex_bubble_c = 1'b1;
          flush_inc     = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            fcnt_d  = FLUSH_LOAD;
            state_d = FLUSH;
          end
        end else if (id_valid && halt_req) begin
          pc_write_c    = 1'b0;
          ifid_write_c  = 1'b0;
          idex_bubble_c = 1'b1;
          state_d       = HALTED;
        end
      end
      FLUSH: begin
        if (mem_busy) begin
          pipe_freeze_c = 1'b1;
          pc_write_c    = 1'b0;
          ifid_write_c  = 1'b0;
          stall_inc     = 1'b1;
          fcnt_d        = 3'd0;
          state_d       = MEM_WAIT;
        end else begin
          if_flush_c    = 1'b1;
          idex_bubble_c = 1'b1;
          fcnt_d        = fcnt_q - 3'd1;
          if (fcnt_q <= 3'd1) state_d = RUN;
        end
      end
      HALTED: begin
        pc_write_c    = 1'b0;
        ifid_write_c  = 1'b0;
        idex_bubble_c = 1'b1;
        halted_c      = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      fcnt_q      <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // While reset is held the pipe is kept empty: IF flushed, ID/EX bubbled, PC frozen
  assign pc_write    = reset ? pc_write_c    : 1'b0;
  assign pc_sel      = reset ? pc_sel_c      : 1'b0;
  assign ifid_write  = reset ? ifid_write_c  : 1'b0;
  assign if_flush    = reset ? if_flush_c    : 1'b1;
  assign idex_bubble = reset ? idex_bubble_c : 1'b1;
  assign pipe_freeze = reset ? pipe_freeze_c : 1'b0;
  assign halted      = reset ? halted_c      : 1'b0;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: two hazard controllers (FLUSH_CYCLES=3/CNT_W=16 and FLUSH_CYCLES=1/CNT_W=2)
// driven by directed then random stimulus and compared with a behavioural model.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use_rs1, id_use_rs2, idex_memread, branch_taken, halt_req, mem_busy;
  logic [4:0] id_rs1, id_rs2, idex_rd;

  logic        pc_write_a, pc_sel_a, ifid_write_a, if_flush_a, idex_bubble_a, pipe_freeze_a, halted_a;
  logic [15:0] stall_cnt_a, flush_cnt_a;
  logic        pc_write_b, pc_sel_b, ifid_write_b, if_flush_b, idex_bubble_b, pipe_freeze_b, halted_b;
  logic [1:0]  stall_cnt_b, flush_cnt_b;

  int checks = 0;
  int errors = 0;

  // Model state per DUT: halted flag, remaining flush cycles after this one, counters
  bit halted_m[2];
  int flush_left_m[2];
  int stall_m[2];
  int flush_m[2];
  int fc_m[2]  = '{3, 1};
  int max_m[2] = '{65535, 3};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .branch_taken(branch_taken), .halt_req(halt_req), .mem_busy(mem_busy),
    .pc_write(pc_write_a), .pc_sel(pc_sel_a), .ifid_write(ifid_write_a), .if_flush(if_flush_a),
    .idex_bubble(idex_bubble_a), .pipe_freeze(pipe_freeze_a), .halted(halted_a),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .branch_taken(branch_taken), .halt_req(halt_req), .mem_busy(mem_busy),
    .pc_write(pc_write_b), .pc_sel(pc_sel_b), .ifid_write(ifid_write_b), .if_flush(if_flush_b),
    .idex_bubble(idex_bubble_b), .pipe_freeze(pipe_freeze_b), .halted(halted_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [6:0] dutOuts(input int k);
    if (k == 0) return {pc_write_a, pc_sel_a, ifid_write_a, if_flush_a, idex_bubble_a, pipe_freeze_a, halted_a};
    return {pc_write_b, pc_sel_b, ifid_write_b, if_flush_b, idex_bubble_b, pipe_freeze_b, halted_b};
  endfunction

  function automatic int dutStall(input int k);
    return (k == 0) ? int'(stall_cnt_a) : int'(stall_cnt_b);
  endfunction

  function automatic int dutFlush(input int k);
    return (k == 0) ? int'(flush_cnt_a) : int'(flush_cnt_b);
  endfunction

  function automatic int satInc(input int v, input int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  // Expected outputs {pc_write,pc_sel,ifid_write,if_flush,idex_bubble,pipe_freeze,halted};
  // also advances the model to the state after the coming clock edge
  task automatic modelStep(input int k, output logic [6:0] exp);
    bit lu;
    lu = idex_memread && (idex_rd != 0) && id_valid &&
         ((id_use_rs1 && idex_rd == id_rs1) || (id_use_rs2 && idex_rd == id_rs2));
    exp = 7'b1010000;
    if (halted_m[k]) begin
      exp = 7'b0000101;
    end else if (flush_left_m[k] > 0) begin
      if (mem_busy) begin
        exp = 7'b0000010;
        stall_m[k] = satInc(stall_m[k], max_m[k]);
        flush_left_m[k] = 0;
      end else begin
        exp = 7'b1011100;
        flush_left_m[k]--;
      end
    end else if (mem_busy) begin
      exp = 7'b0000010;
      stall_m[k] = satInc(stall_m[k], max_m[k]);
    end else if (lu) begin
      exp = 7'b0000100;
      stall_m[k] = satInc(stall_m[k], max_m[k]);
    end else if (id_valid && branch_taken) begin
      exp = 7'b1111100;
      flush_m[k] = satInc(flush_m[k], max_m[k]);
      flush_left_m[k] = fc_m[k] - 1;
    end else if (id_valid && halt_req) begin
      exp = 7'b0000100;
      halted_m[k] = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic mr, input logic [4:0] rd,
                               input logic br, input logic hr, input logic busy);
    logic [6:0] exp;
    @(negedge clk);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    idex_memread = mr; idex_rd = rd; branch_taken = br; halt_req = hr; mem_busy = busy;
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("stall_cnt%0d", k), dutStall(k), stall_m[k]);
      checkOutput($sformatf("flush_cnt%0d", k), dutFlush(k), flush_m[k]);
      modelStep(k, exp);
      checkOutput($sformatf("outs%0d", k), 32'(dutOuts(k)), 32'(exp));
    end
  endtask

  task automatic idleInputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    idex_memread = 0; idex_rd = 0; branch_taken = 0; halt_req = 0; mem_busy = 0;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b0;
    idleInputs();
    #1;
    for (int k = 0; k < 2; k++) begin
      halted_m[k] = 0; flush_left_m[k] = 0; stall_m[k] = 0; flush_m[k] = 0;
      checkOutput($sformatf("rst_outs%0d", k), 32'(dutOuts(k)), 32'(7'b0001100));
      checkOutput($sformatf("rst_stall%0d", k), dutStall(k), 0);
      checkOutput($sformatf("rst_flush%0d", k), dutFlush(k), 0);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    idleInputs();
    applyReset();
    // load-use on rs1, then released
    applyStimulus(1, 5, 0, 1, 0, 1, 5, 0, 0, 0);
    applyStimulus(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
    // load into x0 never stalls
    applyStimulus(1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    // load-use on rs2
    applyStimulus(1, 1, 7, 1, 1, 1, 7, 0, 0, 0);
    // taken branch, with branch pulses during the flush ignored
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // load-use plus branch: stall first, branch next cycle
    applyStimulus(1, 5, 0, 1, 0, 1, 5, 1, 0, 0);
    applyStimulus(1, 5, 0, 1, 0, 0, 0, 1, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // mem_busy for 4 cycles in RUN
    repeat (4) applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // mem_busy during flush drops the remaining flush
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // reset in the middle of a flush
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // halt persists regardless of inputs
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    applyStimulus(1, 3, 3, 1, 1, 1, 3, 0, 1, 0);
    applyReset();
    // drive the small counters into saturation
    repeat (6) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (5) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    // randomized traffic with occasional resets to leave HALTED
    for (int i = 0; i < 3000; i++) begin
      if (($urandom_range(0, 99) == 0) || (halted_m[0] && $urandom_range(0, 7) == 0)) begin
        applyReset();
      end else begin
        applyStimulus($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                      $urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0,
                      $urandom_range(0, 6) == 0);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
